// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction fetch controller.
// Imported by the FIFO, the interface users and the top.
package imem_pkg;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
  localparam int unsigned IMEM_BYTES_DEF = 5120;
  localparam int unsigned FIFO_DEPTH_DEF = 2;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FAULT
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic pc_legal(
    input logic [31:0] pc,
    input logic [31:0] last_pc
  );
    return (pc[1:0] == 2'b00) && (pc <= last_pc);
  endfunction

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Fetch controller bus: imem read port, redirect input,
// decode-side valid/ready output and fault reporting.
interface imem_fetch_ctrl_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;
  logic [31:0] fault_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata,
    input  redirect_valid, redirect_pc,
    output out_valid, out_instr, out_pc,
    input  out_ready,
    output fault, fault_pc
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata,
    output redirect_valid, redirect_pc,
    input  out_valid, out_instr, out_pc,
    output out_ready,
    input  fault, fault_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush.
// Push while full is accepted only together with a pop.
module fetch_fifo
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t din_i,
  output logic [AW:0]  count_o,
  output logic         empty_o,
  output logic         full_o,
  output fetch_entry_t head_o
);

  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;
  fetch_entry_t  mem_q [DEPTH];

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// PC sequencer for a 1-cycle-latency instruction memory,
// buffering fetched words for decode and reporting bad PCs.
module imem_fetch_ctrl
  import imem_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int unsigned IMEM_BYTES = IMEM_BYTES_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input logic              clk,
  input logic              rst_n,
  imem_fetch_ctrl_if.master bus
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         infl_q, infl_d;
  logic [31:0]  infl_pc_q, infl_pc_d;
  logic         fault_q, fault_d;
  logic [31:0]  fault_pc_q, fault_pc_d;

  logic [CW-1:0] count;
  logic          empty, full;
  fetch_entry_t  head, push_entry;
  logic          redir, room, legal, issue, push, pop;

  // count + inflight already covers the slot the pending response will take
  assign redir = bus.redirect_valid && (state_q != BOOT);
  assign room  = !full && ((count + CW'(infl_q)) < CW'(FIFO_DEPTH));
  assign legal = pc_legal(pc_q, LAST_PC);
  assign issue = (state_q == RUN) && !redir && room && legal;
  assign push  = infl_q && !redir;
  assign pop   = !empty && bus.out_ready;

  assign push_entry.pc    = infl_pc_q;
  assign push_entry.instr = bus.imem_rdata;

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redir),
    .din_i   (push_entry),
    .count_o (count),
    .empty_o (empty),
    .full_o  (full),
    .head_o  (head)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    infl_d     = issue;
    infl_pc_d  = pc_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (!redir && room && !legal) begin
          state_d    = FAULT;
          fault_d    = 1'b1;
          fault_pc_d = pc_q;
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = BOOT;
    endcase
    if (issue) pc_d = pc_q + 32'd4;
    if (redir) begin
      pc_d       = bus.redirect_pc;
      state_d    = RUN;
      fault_d    = 1'b0;
      fault_pc_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      infl_q     <= 1'b0;
      infl_pc_q  <= '0;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      infl_q     <= infl_d;
      infl_pc_q  <= infl_pc_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  assign bus.imem_req  = issue;
  assign bus.imem_addr = pc_q;
  assign bus.out_valid = !empty;
  assign bus.out_instr = empty ? 32'h0 : head.instr;
  assign bus.out_pc    = empty ? 32'h0 : head.pc;
  assign bus.fault     = fault_q;
  assign bus.fault_pc  = fault_pc_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a 1-cycle memory model.
// Inputs change on negedge; outputs are sampled on negedge.
module tb_imem_fetch_ctrl;
  import imem_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  imem_fetch_ctrl_if bus ();

  imem_fetch_ctrl #(
    .RESET_PC   (32'h0),
    .IMEM_BYTES (5120),
    .FIFO_DEPTH (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hC0DE_F00D;
  endfunction

  always @(posedge clk)
    bus.imem_rdata <= bus.imem_req ? word_at(bus.imem_addr) : 32'hDEAD_DEAD;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // leaves the bench at the negedge of cycle 0 (BOOT)
  task automatic do_reset();
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_out(output logic [31:0] pc, output logic [31:0] ins,
                          output int cyc, output bit ok);
    pc = 32'h0; ins = 32'h0; cyc = 0; ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.out_valid) begin
        pc = bus.out_pc; ins = bus.out_instr; ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (bus.imem_req !== 1'b0) begin
      fails++; $display("FAIL reset_req got=%0h exp=0", bus.imem_req);
    end
    tests++;
    if (bus.imem_addr !== 32'h0) begin
      fails++; $display("FAIL reset_addr got=%0h exp=0", bus.imem_addr);
    end
    tests++;
    if ({bus.out_valid, bus.out_instr, bus.out_pc} !== 65'h0) begin
      fails++; $display("FAIL reset_out got v=%0h i=%0h p=%0h exp=0",
                        bus.out_valid, bus.out_instr, bus.out_pc);
    end
    tests++;
    if ({bus.fault, bus.fault_pc} !== 33'h0) begin
      fails++; $display("FAIL reset_fault got f=%0h pc=%0h exp=0",
                        bus.fault, bus.fault_pc);
    end
  endtask

  task automatic test_stream();
    logic [31:0] pc, ins;
    int cyc;
    bit ok;
    do_reset();
    bus.out_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      fails++; $display("FAIL first_req got req=%0h addr=%0h exp req=1 addr=0",
                        bus.imem_req, bus.imem_addr);
    end
    @(negedge clk);
    tests++;
    if (bus.out_valid !== 1'b0 || bus.imem_addr !== 32'h4) begin
      fails++; $display("FAIL cycle2 got v=%0h addr=%0h exp v=0 addr=4",
                        bus.out_valid, bus.imem_addr);
    end
    @(negedge clk);
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0 ||
        bus.out_instr !== word_at(32'h0)) begin
      fails++; $display("FAIL first_out got v=%0h pc=%0h i=%0h exp v=1 pc=0 i=%0h",
                        bus.out_valid, bus.out_pc, bus.out_instr, word_at(32'h0));
    end
    @(negedge clk);
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h4 ||
        bus.out_instr !== word_at(32'h4)) begin
      fails++; $display("FAIL second_out got v=%0h pc=%0h i=%0h exp v=1 pc=4",
                        bus.out_valid, bus.out_pc, bus.out_instr);
    end
    wait_out(pc, ins, cyc, ok);
    tests++;
    if (!ok || pc !== 32'h8 || ins !== word_at(32'h8)) begin
      fails++; $display("FAIL third_out got ok=%0d pc=%0h i=%0h exp pc=8 i=%0h",
                        ok, pc, ins, word_at(32'h8));
    end
  endtask

  task automatic test_stall();
    logic [31:0] pc, ins;
    int cyc, hold_bad, req_bad;
    bit ok;
    do_reset();
    hold_bad = 0;
    req_bad = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c >= 3) begin
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0 ||
            bus.out_instr !== word_at(32'h0)) hold_bad++;
        if (bus.imem_req !== 1'b0) req_bad++;
      end
    end
    tests++;
    if (hold_bad != 0) begin
      fails++; $display("FAIL stall_hold got %0d bad cycles exp 0", hold_bad);
    end
    tests++;
    if (req_bad != 0) begin
      fails++; $display("FAIL stall_req got %0d req cycles exp 0", req_bad);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h4 ||
        bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8) begin
      fails++; $display("FAIL release_1 got v=%0h pc=%0h req=%0h addr=%0h exp 1/4/1/8",
                        bus.out_valid, bus.out_pc, bus.imem_req, bus.imem_addr);
    end
    @(negedge clk);
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++; $display("FAIL release_2 got v=%0h exp 0", bus.out_valid);
    end
    wait_out(pc, ins, cyc, ok);
    tests++;
    if (!ok || pc !== 32'h8 || cyc != 1) begin
      fails++; $display("FAIL release_3 got ok=%0d pc=%0h cyc=%0d exp pc=8 cyc=1",
                        ok, pc, cyc);
    end
  endtask

  task automatic test_redirect_squash();
    logic [31:0] pc, ins;
    int cyc;
    bit ok;
    do_reset();
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h20;
    #1;
    tests++;
    if (bus.imem_req !== 1'b0) begin
      fails++; $display("FAIL redir_noreq got req=%0h exp 0", bus.imem_req);
    end
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    #1;
    tests++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h20 || bus.out_valid !== 1'b0) begin
      fails++; $display("FAIL redir_issue got req=%0h addr=%0h v=%0h exp 1/20/0",
                        bus.imem_req, bus.imem_addr, bus.out_valid);
    end
    wait_out(pc, ins, cyc, ok);
    tests++;
    if (!ok || pc !== 32'h20 || ins !== word_at(32'h20) || cyc != 2) begin
      fails++; $display("FAIL redir_out got ok=%0d pc=%0h i=%0h cyc=%0d exp pc=20 cyc=2",
                        ok, pc, ins, cyc);
    end
  endtask

  task automatic test_fault();
    logic [31:0] pc, ins;
    int cyc, req_bad;
    bit ok;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h22;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    #1;
    tests++;
    if (bus.imem_req !== 1'b0 || bus.fault !== 1'b0) begin
      fails++; $display("FAIL bad_pc_try got req=%0h f=%0h exp 0/0",
                        bus.imem_req, bus.fault);
    end
    req_bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.imem_req !== 1'b0 || bus.out_valid !== 1'b0) req_bad++;
    end
    tests++;
    if (bus.fault !== 1'b1 || bus.fault_pc !== 32'h22) begin
      fails++; $display("FAIL fault_set got f=%0h pc=%0h exp 1/22",
                        bus.fault, bus.fault_pc);
    end
    tests++;
    if (req_bad != 0) begin
      fails++; $display("FAIL fault_quiet got %0d bad cycles exp 0", req_bad);
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h10;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    #1;
    tests++;
    if (bus.fault !== 1'b0 || bus.fault_pc !== 32'h0 ||
        bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10) begin
      fails++; $display("FAIL fault_clear got f=%0h fpc=%0h req=%0h addr=%0h exp 0/0/1/10",
                        bus.fault, bus.fault_pc, bus.imem_req, bus.imem_addr);
    end
    wait_out(pc, ins, cyc, ok);
    tests++;
    if (!ok || pc !== 32'h10 || ins !== word_at(32'h10) || cyc != 2) begin
      fails++; $display("FAIL resume_out got ok=%0d pc=%0h cyc=%0d exp pc=10 cyc=2",
                        ok, pc, cyc);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] pc, ins, e;
    int cyc, bad, extra;
    bit ok;
    do_reset();
    bus.out_ready = 1'b1;
    bad = 0;
    e = 32'h0;
    while (e <= 32'd5116) begin
      wait_out(pc, ins, cyc, ok);
      if (!ok) break;
      if (pc !== e || ins !== word_at(e)) bad++;
      e += 32'd4;
    end
    tests++;
    if (bad != 0 || e != 32'd5120) begin
      fails++; $display("FAIL wrap_seq got bad=%0d next=%0d exp bad=0 next=5120", bad, e);
    end
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || bus.imem_req !== 1'b0) extra++;
    end
    tests++;
    if (bus.fault !== 1'b1 || bus.fault_pc !== 32'd5120) begin
      fails++; $display("FAIL wrap_fault got f=%0h pc=%0d exp 1/5120",
                        bus.fault, bus.fault_pc);
    end
    tests++;
    if (extra != 0) begin
      fails++; $display("FAIL wrap_quiet got %0d busy cycles exp 0", extra);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] pc, ins;
    int cyc;
    bit ok;
    do_reset();
    repeat (3) @(negedge clk);
    tests++;
    if (bus.out_valid !== 1'b1) begin
      fails++; $display("FAIL mid_pre got v=%0h exp 1", bus.out_valid);
    end
    rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.out_valid !== 1'b0 || bus.imem_req !== 1'b0 ||
        bus.imem_addr !== 32'h0 || bus.fault !== 1'b0) begin
      fails++; $display("FAIL mid_reset got v=%0h req=%0h addr=%0h f=%0h exp 0/0/0/0",
                        bus.out_valid, bus.imem_req, bus.imem_addr, bus.fault);
    end
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    wait_out(pc, ins, cyc, ok);
    tests++;
    if (!ok || pc !== 32'h0 || ins !== word_at(32'h0) || cyc != 3) begin
      fails++; $display("FAIL mid_refetch got ok=%0d pc=%0h cyc=%0d exp pc=0 cyc=3",
                        ok, pc, cyc);
    end
    wait_out(pc, ins, cyc, ok);
    tests++;
    if (!ok || pc !== 32'h4 || ins !== word_at(32'h4)) begin
      fails++; $display("FAIL mid_second got ok=%0d pc=%0h exp pc=4", ok, pc);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_squash();
    test_fault();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
